// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD to binary converter using reverse double-dabble
// (shift right, then subtract 3 from every BCD digit that is >= 8).
module bcd2bin #(
  parameter int unsigned No_bits = 14
) (
  input  logic               bcd2bin_clk,
  input  logic               reset_,
  input  logic               start_i,
  input  logic [3:0]         D12,
  input  logic [3:0]         D8,
  input  logic [3:0]         D4,
  input  logic [3:0]         D0,
  output logic [No_bits-1:0] bin_o,
  output logic               done_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned W = 16 + No_bits;

  typedef enum logic [1:0] {IDLE, SHIFT, ADJ, DONE} state_t;

  state_t               state_q, state_d;
  logic [15:0]          bcd_q, bcd_d;
  logic [No_bits-1:0]   sr_q, sr_d;
  logic [4:0]           k_q, k_d;
  logic [No_bits-1:0]   bin_q, bin_d;
  logic                 err_q, err_d;

  logic [W-1:0]         shifted;
  logic [15:0]          adj;
  logic                 bad_digit;

  always_ff @(posedge bcd2bin_clk) begin
    if (!reset_) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      sr_q    <= '0;
      k_q     <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      k_q     <= k_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  // The BCD and binary registers shift as one word: B0[0] falls into Bin's MSB.
  always_comb begin
    shifted = {bcd_q, sr_q} >> 1;
    adj     = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd8)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] - 4'd3;
    end
    bad_digit = (D12 > 4'd9) || (D8 > 4'd9) || (D4 > 4'd9) || (D0 > 4'd9);
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sr_d    = sr_q;
    k_d     = k_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            bcd_d   = {D12, D8, D4, D0};
            sr_d    = '0;
            k_d     = 5'(No_bits);
            err_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = shifted[W-1:No_bits];
        sr_d  = shifted[No_bits-1:0];
        k_d   = k_q - 5'd1;
        if (k_q == 5'd1) begin
          bin_d   = shifted[No_bits-1:0];
          state_d = DONE;
        end else begin
          state_d = ADJ;
        end
      end
      ADJ: begin
        bcd_d   = adj;
        state_d = SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bin_o  = bin_q;
  assign err_o  = err_q;
  assign done_o = (state_q == DONE);
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin with hand-computed expected values.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        reset_;
  logic        start_i;
  logic [3:0]  D12, D8, D4, D0;
  logic [13:0] bin_o;
  logic        done_o, busy_o, err_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int n;
  int snap;

  bcd2bin #(.No_bits(14)) dut (
    .bcd2bin_clk(clk),
    .reset_     (reset_),
    .start_i    (start_i),
    .D12        (D12),
    .D8         (D8),
    .D4         (D4),
    .D0         (D0),
    .bin_o      (bin_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_o) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    D12 = a; D8 = b; D4 = c; D0 = d;
  endtask

  // Counts edges after the accepting edge until done_o is seen (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done_o && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset_ = 1'b0; start_i = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    tick(); tick();
    chk("rst_bin",  32'(bin_o),  32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err",  32'(err_o),  32'd0);
    reset_ = 1'b1;
    tick();

    // 0000
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("z_busy", 32'(busy_o), 32'd1);
    wait_done(n);
    chk("z_lat", 32'(n), 32'd27);
    chk("z_bin", 32'(bin_o), 32'd0);
    chk("z_err", 32'(err_o), 32'd0);
    tick();

    // 9999
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    start_i = 1'b1; tick(); start_i = 1'b0;
    wait_done(n);
    chk("n9_lat", 32'(n), 32'd27);
    chk("n9_bin", 32'(bin_o), 32'h270F);
    tick();
    chk("n9_done_1cyc", 32'(done_o), 32'd0);
    chk("n9_busy_low",  32'(busy_o), 32'd0);

    // 1234 then 0080 back-to-back, start held high
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    start_i = 1'b1; tick();
    wait_done(n);
    chk("b1_lat", 32'(n), 32'd27);
    chk("b1_bin", 32'(bin_o), 32'h4D2);
    set_digits(4'd0, 4'd0, 4'd8, 4'd0);
    tick();
    chk("b2_idle", 32'(busy_o), 32'd0);
    tick();
    chk("b2_accept", 32'(busy_o), 32'd1);
    chk("b2_prev_visible", 32'(bin_o), 32'h4D2);
    start_i = 1'b0;
    wait_done(n);
    chk("b2_lat", 32'(n), 32'd27);
    chk("b2_bin", 32'(bin_o), 32'h50);
    tick();

    // Invalid digit, then valid 0005
    set_digits(4'd0, 4'd0, 4'hA, 4'd0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("bad_done", 32'(done_o), 32'd1);
    chk("bad_err",  32'(err_o),  32'd1);
    chk("bad_bin",  32'(bin_o),  32'd0);
    tick();
    chk("bad_done_1cyc", 32'(done_o), 32'd0);
    chk("bad_err_held",  32'(err_o),  32'd1);
    set_digits(4'd0, 4'd0, 4'd0, 4'd5);
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("v5_err_clr", 32'(err_o), 32'd0);
    wait_done(n);
    chk("v5_lat", 32'(n), 32'd27);
    chk("v5_bin", 32'(bin_o), 32'd5);
    tick();

    // 0500 with start toggling and digits changing while busy
    set_digits(4'd0, 4'd5, 4'd0, 4'd0);
    start_i = 1'b1; tick();
    snap = done_cnt;
    for (int i = 0; i < 26; i++) begin
      start_i = i[0];
      set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end
    chk("t_no_early_done", 32'(done_o), 32'd0);
    chk("t_bin_stable",    32'(bin_o),  32'd5);
    start_i = 1'b0;
    tick();
    chk("t_done", 32'(done_o), 32'd1);
    chk("t_bin",  32'(bin_o),  32'h1F4);
    tick();
    chk("t_one_done", 32'(done_cnt - snap), 32'd1);
    chk("t_idle",     32'(busy_o), 32'd0);

    // 9999 aborted by reset on cycle 10, then 0042
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (9) tick();
    reset_ = 1'b0; tick(); reset_ = 1'b1;
    snap = done_cnt;
    chk("ab_bin",  32'(bin_o),  32'd0);
    chk("ab_busy", 32'(busy_o), 32'd0);
    chk("ab_done", 32'(done_o), 32'd0);
    repeat (30) tick();
    chk("ab_no_done", 32'(done_cnt - snap), 32'd0);
    set_digits(4'd0, 4'd0, 4'd4, 4'd2);
    start_i = 1'b1; tick(); start_i = 1'b0;
    wait_done(n);
    chk("f_lat", 32'(n), 32'd27);
    chk("f_bin", 32'(bin_o), 32'h2A);
    chk("f_err", 32'(err_o), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
Name: bcd2bin

Overview:
Sequential BCD-to-binary converter; the inverse path of the existing binary-to-BCD unit. Accepts a 4-digit packed BCD value (thousands..units) on a start pulse. Converts it with reverse double-dabble: shift right, then subtract 3 from any digit >= 8. Presents a stable binary result with a one-cycle done strobe, plus an error flag for non-decimal digits.

Parameters:
No_bits, 14, width of binary result and number of shift iterations; legal range 14..16 (9999 < 2^14).

Ports:
bcd2bin_clk  input  1  clock; all state updates on rising edge
reset_  input  1  synchronous active-low reset, sampled on rising edge of bcd2bin_clk
start_i  input  1  request; sampled only in IDLE
D12  input  4  BCD thousands digit
D8  input  4  BCD hundreds digit
D4  input  4  BCD tens digit
D0  input  4  BCD units digit
bin_o  output  No_bits  binary result; registered, held until next completion
done_o  output  1  one-cycle completion strobe
busy_o  output  1  high in every state except IDLE
err_o  output  1  last accepted request had a digit > 9; held until next accepted start

Behaviour:
- Reset (reset_ low at an edge):
  - state=IDLE; bin_o=0, done_o=0, err_o=0, busy_o=0.
  - Internal BCD shift register, Bin shift register and iteration counter K cleared.
  - Reset mid-conversion aborts it; no done_o is produced.
- Datapath:
  - 16-bit BCD shift register {B12,B8,B4,B0}.
  - No_bits Bin register.
  - K counter, 5 bits.
- FSM states: IDLE, SHIFT, ADJ, DONE.
- IDLE:
  - busy_o=0.
  - If start_i=1 and all digits <= 9: load digits into B*, clear Bin, K=No_bits, err_o<=0, go to SHIFT.
  - If start_i=1 and any digit > 9: err_o<=1, bin_o<=0, go to DONE.
  - start_i=0: stay in IDLE.
- SHIFT:
  - Shift {B12,B8,B4,B0,Bin} right 1 bit as one concatenation; B0[0] enters Bin[No_bits-1]; 0 enters B12[3].
  - K<=K-1.
  - If K==1 before the decrement (last shift): bin_o<=shifted Bin value, go to DONE. Otherwise go to ADJ.
- ADJ:
  - For each digit independently: if digit >= 8, digit<=digit-3 (4-bit arithmetic, never underflows); else hold. Bin holds.
  - Go to SHIFT.
- DONE:
  - done_o=1 for exactly this cycle; go to IDLE next edge; start_i ignored here.
- Latency, valid request:
  - No_bits shifts and No_bits-1 adjusts.
  - done_o is high in the cycle beginning 2*No_bits-1 edges after the start-sampling edge (27 for default).
  - Throughput: one conversion per 2*No_bits+1 cycles.
- Latency, invalid request: done_o high in the cycle immediately after the start-sampling edge; err_o=1, bin_o=0.
- bin_o: changes only on the DONE-entry edge or reset; stable during conversion; the previous result is visible while busy.
- start_i while busy_o=1 or in DONE: ignored, no queuing.
- D* inputs are sampled only on the accepting edge; later changes have no effect.
- err_o: cleared only by reset or the next accepted valid start.
- Width: No_bits > 14 only adds shifts that move zeros from the emptied BCD register; result is unchanged.

Test Plan:
- 0000 with start pulse -> done_o high 27 cycles after acceptance; bin_o=0, err_o=0.
- D12..D0=9,9,9,9 -> bin_o=14'h270F (9999), done_o single cycle, busy_o low the following cycle.
- 1,2,3,4 then 0,0,8,0 back-to-back (start held high) -> bin_o=1234 (0x4D2), then 80 (0x50); second start accepted on the first IDLE cycle.
- D4=4'hA -> err_o=1, bin_o=0, done_o the cycle after acceptance; a following valid 0,0,0,5 gives err_o=0, bin_o=5.
- Start 0,5,0,0, then toggle start_i and change D* during busy -> bin_o=500, no extra done_o, changes ignored.
- Start 9,9,9,9, assert reset_ low on cycle 10 for one edge -> bin_o=0, busy_o=0, no done_o; a new 0,0,4,2 request gives 42.
